// File: rtl/fadd32_close_norm_round.sv
// Close-path back end of the fp32 adder: normalise the difference, round it, pack result and flags.
// Latency: 2 cycles (s1 registers the inputs, s2 registers the packed result).
// Backpressure: valid/ready chain, in_ready_o combinational from out_ready_i, no skid buffer.
module fadd32_close_norm_round #(
  parameter int EXP_W  = 8,
  parameter int FRAC_W = 23
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [49:0] close_sum_i,
  input  logic        sign_i,
  input  logic [7:0]  exp_large_i,
  input  logic [2:0]  rm_i,
  input  logic [5:0]  lza_i,
  input  logic        lza_limited_by_exp_i,
  input  logic [26:0] overflow_l_mask_i,
  input  logic [25:0] overflow_g_mask_i,
  input  logic [24:0] overflow_s_mask_i,
  input  logic [25:0] normal_l_mask_i,
  input  logic [24:0] normal_g_mask_i,
  input  logic [23:0] normal_s_mask_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] res_o,
  output logic [4:0]  fflags_o
);
  localparam int MANT_W = FRAC_W + 1;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  // Pipeline control
  logic w_s1_en;
  logic w_s2_en;
  logic r_s1_valid;
  logic r_s2_valid;

  // Stage-1 payload
  logic [49:0] r_close_sum;
  logic        r_sign;
  logic [7:0]  r_exp_large;
  logic [2:0]  r_rm;
  logic [5:0]  r_lza;
  logic        r_lim;
  logic [26:0] r_ovf_l_mask;
  logic [25:0] r_ovf_g_mask;
  logic [24:0] r_ovf_s_mask;
  logic [25:0] r_nrm_l_mask;
  logic [24:0] r_nrm_g_mask;
  logic [23:0] r_nrm_s_mask;

  // Stage-2 payload
  logic [31:0] r_res;
  logic [4:0]  r_flags;

  // Normalise/round datapath between the stages
  logic [49:0]       w_sh;
  logic [24:0]       w_sh_top;
  logic              w_ovf;
  logic [MANT_W-1:0] w_mant;
  logic              w_l;
  logic              w_g;
  logic              w_s;
  logic              w_inc;
  logic              w_carry;
  logic [FRAC_W-1:0] w_frac;
  logic [EXP_W:0]    w_exp_pre;
  logic [EXP_W-1:0]  w_exp;
  logic              w_norm;
  logic              w_hidden_up;
  logic              w_nx;
  logic              w_uf;
  logic              w_cancel;
  logic [31:0]       w_res;
  logic [4:0]        w_flags;

  assign w_s2_en    = ~r_s2_valid | out_ready_i;
  assign w_s1_en    = ~r_s1_valid | w_s2_en;
  assign in_ready_o = w_s1_en;

  assign out_valid_o = r_s2_valid;
  assign res_o       = r_res;
  assign fflags_o    = r_flags;

  // Stage 1: capture the incoming beat whenever the stage can advance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid   <= 1'b0;
      r_close_sum  <= '0;
      r_sign       <= 1'b0;
      r_exp_large  <= '0;
      r_rm         <= '0;
      r_lza        <= '0;
      r_lim        <= 1'b0;
      r_ovf_l_mask <= '0;
      r_ovf_g_mask <= '0;
      r_ovf_s_mask <= '0;
      r_nrm_l_mask <= '0;
      r_nrm_g_mask <= '0;
      r_nrm_s_mask <= '0;
    end else if (w_s1_en) begin
      r_s1_valid <= in_valid_i;
      if (in_valid_i) begin
        r_close_sum  <= close_sum_i;
        r_sign       <= sign_i;
        r_exp_large  <= exp_large_i;
        r_rm         <= rm_i;
        r_lza        <= lza_i;
        r_lim        <= lza_limited_by_exp_i;
        r_ovf_l_mask <= overflow_l_mask_i;
        r_ovf_g_mask <= overflow_g_mask_i;
        r_ovf_s_mask <= overflow_s_mask_i;
        r_nrm_l_mask <= normal_l_mask_i;
        r_nrm_g_mask <= normal_g_mask_i;
        r_nrm_s_mask <= normal_s_mask_i;
      end
    end
  end

  // Normalise, pick L/G/S from the precomputed masks, round and pack.
  always_comb begin
    w_sh     = r_close_sum << r_lza;
    w_ovf    = w_sh[49];
    w_sh_top = 25'(w_sh >> 25);
    w_mant   = w_ovf ? w_sh_top[24:1] : w_sh_top[23:0];

    // Masks index the unshifted sum, so the LZA shift never sits on this path.
    w_l = |(r_close_sum[26:0] & (w_ovf ? r_ovf_l_mask : {1'b0, r_nrm_l_mask}));
    w_g = |(r_close_sum[25:0] & (w_ovf ? r_ovf_g_mask : {1'b0, r_nrm_g_mask}));
    w_s = |(r_close_sum[24:0] & (w_ovf ? r_ovf_s_mask : {1'b0, r_nrm_s_mask}));

    w_inc = 1'b0;
    case (r_rm)
      RM_RNE:  w_inc = w_g & (w_l | w_s);
      RM_RTZ:  w_inc = 1'b0;
      RM_RDN:  w_inc = r_sign & (w_g | w_s);
      RM_RUP:  w_inc = ~r_sign & (w_g | w_s);
      RM_RMM:  w_inc = w_g;
      default: w_inc = 1'b0;
    endcase

    // The LZA clamp guarantees this never goes negative.
    w_exp_pre = r_lim ? '0
                      : ({1'b0, r_exp_large} - {3'b000, r_lza} + {{EXP_W{1'b0}}, w_ovf});

    {w_carry, w_frac} = {1'b0, w_mant[FRAC_W-1:0]} + {{FRAC_W{1'b0}}, w_inc};

    // A denormal whose hidden bit is (or becomes) set is really exponent 1.
    w_norm      = w_carry | w_mant[MANT_W-1];
    w_hidden_up = w_carry | ((w_exp_pre == '0) & w_mant[MANT_W-1]);
    w_exp       = w_exp_pre[EXP_W-1:0] + {{(EXP_W-1){1'b0}}, w_hidden_up};

    w_nx     = w_g | w_s;
    w_uf     = w_nx & (w_exp_pre == '0) & ~w_norm;
    w_cancel = (r_close_sum == '0);

    // Exact cancellation gives +0, or -0 when rounding down.
    w_res   = w_cancel ? {(r_rm == RM_RDN), 31'd0} : {r_sign, w_exp, w_frac};
    w_flags = w_cancel ? 5'd0 : {3'b000, w_uf, w_nx};
  end

  // Stage 2: register the packed result, hold it while downstream stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_res      <= '0;
      r_flags    <= '0;
    end else if (w_s2_en) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_res   <= w_res;
        r_flags <= w_flags;
      end
    end
  end

endmodule
